countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 102 ++++++++++
 tb/tb_countdown_timer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Seconds countdown timer with BCD display digits, pause/resume and an expiry alarm.
// Count and state are registered; alarm is a pure gate of the expired flag with the blink input.
module countdown_timer #(
    parameter int MAX_SECS = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       blink_05hz,
    input  logic       clr,
    input  logic       load,
    input  logic [6:0] load_secs,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] secs_tens,
    output logic [3:0] secs_ones,
    output logic       running,
    output logic       expired,
    output logic       done,
    output logic       alarm,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] tens_nxt, ones_nxt;
    logic       done_nxt;
    logic [6:0] clamped;
    logic       count_zero, count_one;

    assign clamped    = (load_secs > 7'(MAX_SECS)) ? 7'(MAX_SECS) : load_secs;
    assign count_zero = (secs_tens == 4'd0) && (secs_ones == 4'd0);
    assign count_one  = (secs_tens == 4'd0) && (secs_ones == 4'd1);

    always_comb begin
        state_nxt = state;
        tens_nxt  = secs_tens;
        ones_nxt  = secs_ones;
        done_nxt  = 1'b0;
        if (clr) begin
            state_nxt = IDLE;
            tens_nxt  = 4'd0;
            ones_nxt  = 4'd0;
        end else if (load && (state != RUN)) begin
            state_nxt = IDLE;
            tens_nxt  = 4'(clamped / 7'd10);
            ones_nxt  = 4'(clamped % 7'd10);
        end else begin
            case (state)
                IDLE, PAUSED: begin
                    if (start && !count_zero) state_nxt = RUN;
                end
                RUN: begin
                    // A coincident pause still takes the decrement; expiry overrides the pause.
                    if (tick_1hz && !count_zero) begin
                        if (secs_ones == 4'd0) begin
                            ones_nxt = 4'd9;
                            tens_nxt = secs_tens - 4'd1;
                        end else begin
                            ones_nxt = secs_ones - 4'd1;
                        end
                        if (count_one) begin
                            state_nxt = EXPIRED;
                            done_nxt  = 1'b1;
                        end else if (pause) begin
                            state_nxt = PAUSED;
                        end
                    end else if (pause) begin
                        state_nxt = PAUSED;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            secs_tens <= 4'd0;
            secs_ones <= 4'd0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            secs_tens <= tens_nxt;
            secs_ones <= ones_nxt;
            done      <= done_nxt;
        end
    end

    assign running   = (state == RUN);
    assign expired   = (state == EXPIRED);
    assign alarm     = expired & blink_05hz;
    assign state_dbg = state;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: a driver queues hand-computed expected outputs,
// and a monitor compares them against the DUT one clock after each driven cycle.
module tb_countdown_timer;
    // Inputs are driven on the falling edge; outputs are sampled 1 time unit after the rising edge.

    localparam logic [4:0] C_NONE  = 5'b00000;
    localparam logic [4:0] C_CLR   = 5'b10000;
    localparam logic [4:0] C_LOAD  = 5'b01000;
    localparam logic [4:0] C_START = 5'b00100;
    localparam logic [4:0] C_PAUSE = 5'b00010;
    localparam logic [4:0] C_TICK  = 5'b00001;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PAUS = 2'd2;
    localparam logic [1:0] S_EXP  = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       blink_05hz = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [6:0] load_secs = 7'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] secs_tens, secs_ones;
    logic       running, expired, done, alarm;
    logic [1:0] state_dbg;

    logic [13:0] exp_q[$];
    int total = 0;
    int bad = 0;

    countdown_timer #(.MAX_SECS(99)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .blink_05hz(blink_05hz),
        .clr(clr), .load(load), .load_secs(load_secs), .start(start), .pause(pause),
        .secs_tens(secs_tens), .secs_ones(secs_ones), .running(running),
        .expired(expired), .done(done), .alarm(alarm), .state_dbg(state_dbg)
    );

    always #10 clk = ~clk;

    // Driver: one cycle of stimulus plus the output vector expected after the next edge.
    task automatic cyc(input logic [4:0] c, input logic [6:0] ls, input logic b,
                       input logic [3:0] t, input logic [3:0] o, input logic [1:0] st,
                       input logic d, input logic a);
        @(negedge clk);
        {clr, load, start, pause, tick_1hz} = c;
        load_secs  = ls;
        blink_05hz = b;
        exp_q.push_back({t, o, st, st == S_RUN, st == S_EXP, d, a});
    endtask

    task automatic idle(input int n, input logic [3:0] t, input logic [3:0] o, input logic [1:0] st);
        for (int i = 0; i < n; i++) cyc(C_NONE, 7'd0, 1'b0, t, o, st, 1'b0, 1'b0);
    endtask

    // Monitor
    initial begin
        logic [13:0] e, act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {secs_tens, secs_ones, state_dbg, running, expired, done, alarm};
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL cycle_check t=%0t got tens=%0d ones=%0d st=%0d run=%0b exp=%0b done=%0b alarm=%0b required tens=%0d ones=%0d st=%0d run=%0b exp=%0b done=%0b alarm=%0b",
                             $time, act[13:10], act[9:6], act[5:4], act[3], act[2], act[1], act[0],
                             e[13:10], e[9:6], e[5:4], e[3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({secs_tens, secs_ones, running, expired, done, alarm, state_dbg} !== 14'd0) begin
            bad++;
            $display("FAIL reset_state got %h required 0",
                     {secs_tens, secs_ones, running, expired, done, alarm, state_dbg});
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Basic countdown from 3
        cyc(C_LOAD, 7'd3, 1'b0, 4'd0, 4'd3, S_IDLE, 1'b0, 1'b0);
        cyc(C_START, 7'd0, 1'b0, 4'd0, 4'd3, S_RUN, 1'b0, 1'b0);
        idle(4, 4'd0, 4'd3, S_RUN);
        cyc(C_TICK, 7'd0, 1'b0, 4'd0, 4'd2, S_RUN, 1'b0, 1'b0);
        idle(4, 4'd0, 4'd2, S_RUN);
        cyc(C_TICK, 7'd0, 1'b0, 4'd0, 4'd1, S_RUN, 1'b0, 1'b0);
        idle(4, 4'd0, 4'd1, S_RUN);
        cyc(C_TICK, 7'd0, 1'b0, 4'd0, 4'd0, S_EXP, 1'b1, 1'b0);
        idle(3, 4'd0, 4'd0, S_EXP);
        cyc(C_TICK, 7'd0, 1'b0, 4'd0, 4'd0, S_EXP, 1'b0, 1'b0);
        cyc(C_START, 7'd0, 1'b0, 4'd0, 4'd0, S_EXP, 1'b0, 1'b0);

        // Clamp and BCD borrow
        cyc(C_LOAD, 7'd120, 1'b0, 4'd9, 4'd9, S_IDLE, 1'b0, 1'b0);
        cyc(C_LOAD, 7'd10, 1'b0, 4'd1, 4'd0, S_IDLE, 1'b0, 1'b0);
        cyc(C_START, 7'd0, 1'b0, 4'd1, 4'd0, S_RUN, 1'b0, 1'b0);
        cyc(C_TICK, 7'd0, 1'b0, 4'd0, 4'd9, S_RUN, 1'b0, 1'b0);
        cyc(C_CLR, 7'd0, 1'b0, 4'd0, 4'd0, S_IDLE, 1'b0, 1'b0);
        cyc(C_START, 7'd0, 1'b0, 4'd0, 4'd0, S_IDLE, 1'b0, 1'b0);
        cyc(C_LOAD, 7'd99, 1'b0, 4'd9, 4'd9, S_IDLE, 1'b0, 1'b0);

        // Pause and resume from 5
        cyc(C_LOAD, 7'd5, 1'b0, 4'd0, 4'd5, S_IDLE, 1'b0, 1'b0);
        cyc(C_START, 7'd0, 1'b0, 4'd0, 4'd5, S_RUN, 1'b0, 1'b0);
        cyc(C_TICK, 7'd0, 1'b0, 4'd0, 4'd4, S_RUN, 1'b0, 1'b0);
        cyc(C_TICK, 7'd0, 1'b0, 4'd0, 4'd3, S_RUN, 1'b0, 1'b0);
        cyc(C_PAUSE, 7'd0, 1'b0, 4'd0, 4'd3, S_PAUS, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(C_TICK, 7'd0, 1'b0, 4'd0, 4'd3, S_PAUS, 1'b0, 1'b0);
        cyc(C_START, 7'd0, 1'b0, 4'd0, 4'd3, S_RUN, 1'b0, 1'b0);
        cyc(C_TICK, 7'd0, 1'b0, 4'd0, 4'd2, S_RUN, 1'b0, 1'b0);
        cyc(C_TICK, 7'd0, 1'b0, 4'd0, 4'd1, S_RUN, 1'b0, 1'b0);
        cyc(C_TICK, 7'd0, 1'b0, 4'd0, 4'd0, S_EXP, 1'b1, 1'b0);
        idle(2, 4'd0, 4'd0, S_EXP);

        // Simultaneous events
        cyc(C_LOAD, 7'd1, 1'b0, 4'd0, 4'd1, S_IDLE, 1'b0, 1'b0);
        cyc(C_START, 7'd0, 1'b0, 4'd0, 4'd1, S_RUN, 1'b0, 1'b0);
        cyc(C_PAUSE | C_TICK, 7'd0, 1'b0, 4'd0, 4'd0, S_EXP, 1'b1, 1'b0);
        idle(1, 4'd0, 4'd0, S_EXP);
        cyc(C_LOAD, 7'd2, 1'b0, 4'd0, 4'd2, S_IDLE, 1'b0, 1'b0);
        cyc(C_START, 7'd0, 1'b0, 4'd0, 4'd2, S_RUN, 1'b0, 1'b0);
        cyc(C_PAUSE | C_TICK, 7'd0, 1'b0, 4'd0, 4'd1, S_PAUS, 1'b0, 1'b0);
        cyc(C_LOAD | C_START, 7'd42, 1'b0, 4'd4, 4'd2, S_IDLE, 1'b0, 1'b0);
        cyc(C_START, 7'd0, 1'b0, 4'd4, 4'd2, S_RUN, 1'b0, 1'b0);
        cyc(C_LOAD, 7'd7, 1'b0, 4'd4, 4'd2, S_RUN, 1'b0, 1'b0);
        cyc(C_LOAD | C_TICK, 7'd7, 1'b0, 4'd4, 4'd1, S_RUN, 1'b0, 1'b0);
        cyc(C_CLR | C_TICK, 7'd0, 1'b0, 4'd0, 4'd0, S_IDLE, 1'b0, 1'b0);

        // Alarm follows blink while expired
        cyc(C_LOAD, 7'd1, 1'b0, 4'd0, 4'd1, S_IDLE, 1'b0, 1'b0);
        cyc(C_START, 7'd0, 1'b0, 4'd0, 4'd1, S_RUN, 1'b0, 1'b0);
        cyc(C_TICK, 7'd0, 1'b1, 4'd0, 4'd0, S_EXP, 1'b1, 1'b1);
        for (int i = 0; i < 24; i++) begin
            logic b;
            b = ((i / 8) % 2) == 0;
            cyc(C_NONE, 7'd0, b, 4'd0, 4'd0, S_EXP, 1'b0, b);
        end
        cyc(C_CLR, 7'd0, 1'b1, 4'd0, 4'd0, S_IDLE, 1'b0, 1'b0);

        // Reset in the middle of a run at 07
        cyc(C_LOAD, 7'd7, 1'b0, 4'd0, 4'd7, S_IDLE, 1'b0, 1'b0);
        cyc(C_START, 7'd0, 1'b0, 4'd0, 4'd7, S_RUN, 1'b0, 1'b0);
        cyc(C_NONE, 7'd0, 1'b0, 4'd0, 4'd7, S_RUN, 1'b0, 1'b0);
        cyc(C_TICK, 7'd0, 1'b1, 4'd0, 4'd0, S_IDLE, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({secs_tens, secs_ones, running, expired, done, alarm, state_dbg} !== 14'd0) begin
            bad++;
            $display("FAIL reset_async got %h required 0",
                     {secs_tens, secs_ones, running, expired, done, alarm, state_dbg});
        end
        cyc(C_TICK, 7'd0, 1'b1, 4'd0, 4'd0, S_IDLE, 1'b0, 1'b0);
        cyc(C_TICK, 7'd0, 1'b1, 4'd0, 4'd0, S_IDLE, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        {clr, load, start, pause, tick_1hz} = C_NONE;
        blink_05hz = 1'b0;
        idle(2, 4'd0, 4'd0, S_IDLE);
        cyc(C_START, 7'd0, 1'b0, 4'd0, 4'd0, S_IDLE, 1'b0, 1'b0);
        cyc(C_LOAD, 7'd12, 1'b0, 4'd1, 4'd2, S_IDLE, 1'b0, 1'b0);
        cyc(C_START, 7'd0, 1'b0, 4'd1, 4'd2, S_RUN, 1'b0, 1'b0);
        cyc(C_TICK, 7'd0, 1'b0, 4'd1, 4'd1, S_RUN, 1'b0, 1'b0);
        idle(1, 4'd1, 4'd1, S_RUN);

        repeat (4) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got %0d pending required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no end required end of test");
        $fatal(1);
    end

endmodule
